// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-cache refill path.
// Physical address is tag[54:12] | index[11:6] | offset[5:0].
package icache_pkg;

  localparam int PADDR_W     = 55;
  localparam int TAG_W       = 43;
  localparam int INDEX_W     = 6;
  localparam int WAY_W       = 3;
  localparam int OFFSET_W    = 6;
  localparam int LINE_BEATS  = 8;
  localparam int BEAT_W      = 3;
  localparam int DATA_W      = 64;
  localparam int TAG_ENTRY_W = TAG_W + 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    REFILL,
    TAG_WR,
    DONE
  } fill_state_e;

endpackage

// File: rtl/icache_fill_if.sv
// Bundle of the lookup, memory, data-array and tag-array connections of the refill engine.
// The master modport is the refill engine's view; slave is the surrounding cache/memory.
interface icache_fill_if;
  import icache_pkg::*;

  logic                   lookup2fill_valid;
  logic [PADDR_W-1:0]     lookup2fill_paddr;
  logic                   fill2lookup_ready;
  logic                   fill2lookup_done;
  logic                   fill2lookup_err;

  logic                   fill2mem_req_valid;
  logic [PADDR_W-1:0]     fill2mem_req_addr;
  logic                   mem2fill_req_ready;
  logic                   mem2fill_resp_valid;
  logic [DATA_W-1:0]      mem2fill_resp_data;
  logic                   mem2fill_resp_last;
  logic                   mem2fill_resp_err;
  logic                   fill2mem_resp_ready;

  logic                   fill2data_array_valid;
  logic [INDEX_W-1:0]     fill2data_array_index;
  logic [WAY_W-1:0]       fill2data_array_way;
  logic [BEAT_W-1:0]      fill2data_array_offset;
  logic [DATA_W-1:0]      fill2data_array_wdata;

  logic                   lookup2tag_array_valid;
  logic                   fill2tag_array_valid;
  logic [INDEX_W-1:0]     fill2tag_array_index;
  logic [WAY_W-1:0]       fill2tag_array_way;
  logic [TAG_ENTRY_W-1:0] fill2tag_array_wdata;

  modport master (
    input  lookup2fill_valid, lookup2fill_paddr,
    output fill2lookup_ready, fill2lookup_done, fill2lookup_err,
    output fill2mem_req_valid, fill2mem_req_addr,
    input  mem2fill_req_ready,
    input  mem2fill_resp_valid, mem2fill_resp_data, mem2fill_resp_last, mem2fill_resp_err,
    output fill2mem_resp_ready,
    output fill2data_array_valid, fill2data_array_index, fill2data_array_way,
    output fill2data_array_offset, fill2data_array_wdata,
    input  lookup2tag_array_valid,
    output fill2tag_array_valid, fill2tag_array_index, fill2tag_array_way, fill2tag_array_wdata
  );

  modport slave (
    output lookup2fill_valid, lookup2fill_paddr,
    input  fill2lookup_ready, fill2lookup_done, fill2lookup_err,
    input  fill2mem_req_valid, fill2mem_req_addr,
    output mem2fill_req_ready,
    output mem2fill_resp_valid, mem2fill_resp_data, mem2fill_resp_last, mem2fill_resp_err,
    input  fill2mem_resp_ready,
    input  fill2data_array_valid, fill2data_array_index, fill2data_array_way,
    input  fill2data_array_offset, fill2data_array_wdata,
    output lookup2tag_array_valid,
    input  fill2tag_array_valid, fill2tag_array_index, fill2tag_array_way, fill2tag_array_wdata
  );

endinterface

// File: rtl/icache_victim_sel.sv
// Victim way chooser: 3-bit round-robin counter, advanced once per installed line.
// Kept separate so a PLRU policy can replace it without touching the refill FSM.
module icache_victim_sel
  import icache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [WAY_W-1:0] way
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      way <= '0;
    end else if (advance) begin
      way <= way + WAY_W'(1);
    end
  end

endmodule

// File: rtl/icache_fill.sv
// Instruction-cache refill engine: one miss at a time, line read from memory,
// beats written straight into the data array, then a tag install when lookup frees the tag port.
module icache_fill
  import icache_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  icache_fill_if.master bus
);

  fill_state_e        state, state_next;
  logic [PADDR_W-1:0] paddr_q;
  logic [WAY_W-1:0]   way_q;
  logic [WAY_W-1:0]   victim_way;
  logic [BEAT_W-1:0]  beat_q;
  logic               err_q;

  logic latch_req;
  logic beat_fire;
  logic beat_bad;
  logic tag_fire;

  icache_victim_sel u_victim_sel (
    .clock   (clock),
    .reset   (reset),
    .advance (tag_fire),
    .way     (victim_way)
  );

  // Offset bits are masked at capture so the held address is already line aligned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      paddr_q <= '0;
      way_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (latch_req) begin
        paddr_q <= bus.lookup2fill_paddr & LINE_MASK;
        way_q   <= victim_way;
        beat_q  <= '0;
        err_q   <= 1'b0;
      end else if (beat_fire) begin
        beat_q <= beat_q + BEAT_W'(1);
        if (bus.mem2fill_resp_err || beat_bad) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    latch_req  = 1'b0;
    beat_fire  = 1'b0;
    beat_bad   = 1'b0;
    tag_fire   = 1'b0;

    bus.fill2lookup_ready      = 1'b0;
    bus.fill2lookup_done       = 1'b0;
    bus.fill2lookup_err        = 1'b0;
    bus.fill2mem_req_valid     = 1'b0;
    bus.fill2mem_req_addr      = '0;
    bus.fill2mem_resp_ready    = 1'b0;
    bus.fill2data_array_valid  = 1'b0;
    bus.fill2data_array_index  = '0;
    bus.fill2data_array_way    = '0;
    bus.fill2data_array_offset = '0;
    bus.fill2data_array_wdata  = '0;
    bus.fill2tag_array_valid   = 1'b0;
    bus.fill2tag_array_index   = '0;
    bus.fill2tag_array_way     = '0;
    bus.fill2tag_array_wdata   = '0;

    case (state)
      IDLE: begin
        bus.fill2lookup_ready = 1'b1;
        if (bus.lookup2fill_valid) begin
          latch_req  = 1'b1;
          state_next = REQ;
        end
      end

      REQ: begin
        bus.fill2mem_req_valid = 1'b1;
        bus.fill2mem_req_addr  = paddr_q;
        if (bus.mem2fill_req_ready) begin
          state_next = REFILL;
        end
      end

      // A short or overlong burst poisons the fill but we still drain until last.
      REFILL: begin
        bus.fill2mem_resp_ready = 1'b1;
        if (bus.mem2fill_resp_valid) begin
          beat_fire = 1'b1;
          beat_bad  = (bus.mem2fill_resp_last && (beat_q != LAST_BEAT)) ||
                      (!bus.mem2fill_resp_last && (beat_q == LAST_BEAT));
          if (!err_q && !bus.mem2fill_resp_err) begin
            bus.fill2data_array_valid  = 1'b1;
            bus.fill2data_array_index  = paddr_q[OFFSET_W +: INDEX_W];
            bus.fill2data_array_way    = way_q;
            bus.fill2data_array_offset = beat_q;
            bus.fill2data_array_wdata  = bus.mem2fill_resp_data;
          end
          if (bus.mem2fill_resp_last) begin
            state_next = (err_q || bus.mem2fill_resp_err || beat_bad) ? DONE : TAG_WR;
          end
        end
      end

      TAG_WR: begin
        if (!bus.lookup2tag_array_valid) begin
          tag_fire                 = 1'b1;
          bus.fill2tag_array_valid = 1'b1;
          bus.fill2tag_array_index = paddr_q[OFFSET_W +: INDEX_W];
          bus.fill2tag_array_way   = way_q;
          bus.fill2tag_array_wdata = {1'b1, paddr_q[PADDR_W-1 -: TAG_W]};
          state_next               = DONE;
        end
      end

      DONE: begin
        bus.fill2lookup_done = 1'b1;
        bus.fill2lookup_err  = err_q;
        state_next           = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/icache_fill.md
# icache_fill

Refill engine for the instruction cache. It accepts one miss at a time from the lookup stage and issues a line-aligned read to memory. It writes the returned 8×64-bit beats into the data array, then writes the new tag entry into the 8-way × 64-set tag array through that array's fill port, and reports completion to lookup. It also chooses the victim way and keeps tag writes off cycles where the tag array's shared address mux belongs to lookup.

## Interface
- `LINE_BEATS`, 8: beats per 64-byte line; fixed, the beat counter is 3 bits.
- `PADDR_W`, 55: physical address width, split as tag[54:12], index[11:6], offset[5:0].
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `lookup2fill_valid` in 1: miss request.
- `lookup2fill_paddr` in 55: miss address; the offset bits are ignored.
- `fill2lookup_ready` out 1: high only in IDLE.
- `fill2lookup_done` out 1: one-cycle completion pulse.
- `fill2lookup_err` out 1: qualifies `done`; the line was not installed.
- `fill2mem_req_valid` out 1: memory read request.
- `fill2mem_req_addr` out 55: `{paddr[54:6], 6'b0}`.
- `mem2fill_req_ready` in 1: memory accepts the request.
- `mem2fill_resp_valid` in 1: response beat valid.
- `mem2fill_resp_data` in 64: response beat data.
- `mem2fill_resp_last` in 1: final beat.
- `mem2fill_resp_err` in 1: bus error on this beat.
- `fill2mem_resp_ready` out 1: high only in REFILL.
- `fill2data_array_valid` out 1: data write strobe.
- `fill2data_array_index` out 6: data write set.
- `fill2data_array_way` out 3: data write way.
- `fill2data_array_offset` out 3: data write beat number.
- `fill2data_array_wdata` out 64: data write word.
- `lookup2tag_array_valid` in 1: lookup owns the tag array this cycle.
- `fill2tag_array_valid` out 1: tag write strobe.
- `fill2tag_array_index` out 6: tag write set.
- `fill2tag_array_way` out 3: tag write way.
- `fill2tag_array_wdata` out 44: `{1'b1, tag[42:0]}`.

## Operation
- **States:** IDLE, REQ, REFILL, TAG_WR, DONE.
- **IDLE:**
  - `ready`=1.
  - On `lookup2fill_valid`, latch paddr and the victim way (current value of `victim_ctr`).
  - Clear the beat counter and error flag, then go to REQ.
- **REQ:**
  - `fill2mem_req_valid`=1 with the address held stable.
  - On `mem2fill_req_ready`, go to REFILL.
- **REFILL:** every accepted beat does the following.
  - Drives `fill2data_array_valid` combinationally that same cycle, with offset = beat counter and data passed through; no write occurs if the error flag is set or `resp_err`=1.
  - Increments the beat counter, wrapping 7→0.
  - Sets the error flag if `resp_err`=1.
  - If `resp_last`, goes to TAG_WR, or to DONE if an error was seen.
- **REFILL protocol checks (both set the error flag):**
  - `resp_last` arrives on a beat other than 7.
  - Beat 7 arrives without `resp_last`; the engine stays in REFILL until `last`.
- **TAG_WR:**
  - `fill2tag_array_valid`=1 only while `lookup2tag_array_valid`=0; otherwise it waits with no write strobe.
  - After one write cycle, increment `victim_ctr` (3-bit round-robin, wraps 7→0) and go to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, with `err` reflecting the error flag.
  - Return to IDLE.
  - `victim_ctr` does not advance on an error fill.
- **Reset** (any state, mid-refill included):
  - FSM returns to IDLE and `victim_ctr` to 0.
  - All outputs are 0 except `fill2lookup_ready`, which is 1.
  - Beats still in flight from memory after reset are memory's responsibility; the engine drops them because `resp_ready`=0.

## Timing
- Request accepted at edge 0 → `mem_req_valid` high in cycle 1.
- Beat k accepted at edge t → data write appears in cycle t, with no added latency.
- Beat 7 plus `last` at edge t → tag write in cycle t+1 if lookup is idle, and each cycle that lookup holds the array adds one cycle; `done` follows in the next cycle.
- Minimum miss turnaround with zero-wait memory: 12 cycles from request to `done`.
- Lookup must not re-request until after `done` (ready=0 enforces this).
- No simultaneous data and tag writes by construction.

## Structure
- Shared package `icache_pkg`: state enum, `PADDR_W`, `TAG_W`=43, `INDEX_W`=6, `WAY_W`=3, `LINE_BEATS`, tag-entry width 44.
- Single flat module. Victim selection is a small natural sub-module, `icache_victim_sel` (3-bit round-robin counter with advance enable), to allow later PLRU replacement.

## Test plan
- **Clean miss:** paddr 0x12345_67C0, zero-wait memory.
  - 8 data writes at index 0x1F, way 0, offsets 0..7.
  - Tag write `{1, 0x0123456}`-derived entry to index 0x1F, way 0; `done`=1, `err`=0 at cycle 12.
- **Round-robin:** 9 back-to-back misses.
  - Ways 0,1,…,7,0 in sequence.
- **Lookup contention:** hold `lookup2tag_array_valid`=1 for 3 cycles starting at TAG_WR entry.
  - `fill2tag_array_valid` stays 0 for those 3 cycles, then writes once; `done` is delayed by 3 cycles.
- **Bus error on beat 3:**
  - Beats 3..7 produce no data writes and there is no tag write.
  - `done`=1 with `err`=1; the next miss still uses the same way.
- **Early `last` on beat 5:**
  - `err`=1 and no tag write; the FSM returns to IDLE.
- **Reset mid-REFILL after beat 4:**
  - All outputs 0 and `ready`=1 immediately (asynchronous).
  - The next miss uses way 0 and completes cleanly.
